// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache with miss FSM, flush and hit/miss counters
module icache_assoc #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INST_WIDTH  = 32,
    parameter int WAYS        = 2,
    parameter int SETS        = 16,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                              clk,
    input  logic                              rst_in,
    input  logic                              rdy_in,
    input  logic                              inst_en,
    input  logic [ADDR_WIDTH-1:0]             next_PC,
    input  logic                              flush,
    output logic                              cache_rdy,
    output logic [INST_WIDTH-1:0]             next_inst_out,
    output logic                              mem_req,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    input  logic                              resp_valid,
    input  logic [BLOCK_WORDS*INST_WIDTH-1:0] resp_blk,
    output logic [31:0]                       hit_cnt,
    output logic [31:0]                       miss_cnt
);
    localparam int OFF_W = $clog2(BLOCK_WORDS) + 2;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W;
    localparam int WRD_W = BLOCK_WORDS > 1 ? $clog2(BLOCK_WORDS) : 1;
    localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, MISS, DRAIN} state_t;

    state_t                          state_q, state_d;
    logic [SETS-1:0][WAYS-1:0]       valid_q, valid_d;
    logic [SETS-1:0][WAY_W-1:0]      rr_q, rr_d;
    logic                            mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0]           mem_addr_q, mem_addr_d;
    logic [31:0]                     hit_cnt_q, hit_cnt_d;
    logic [31:0]                     miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0]                          tag_mem  [SETS][WAYS];
    logic [BLOCK_WORDS-1:0][INST_WIDTH-1:0]    data_mem [SETS][WAYS];

    logic [IDX_W-1:0]      idx, fill_idx;
    logic [TAG_W-1:0]      tag, fill_tag;
    logic [WRD_W-1:0]      off;
    logic                  hit, fill_we;
    logic [INST_WIDTH-1:0] hit_word;
    logic [WAY_W-1:0]      victim;
    logic                  unused_pc_lsb;

    assign idx           = next_PC[OFF_W +: IDX_W];
    assign tag           = next_PC[ADDR_WIDTH-1 -: TAG_W];
    assign fill_idx      = mem_addr_q[OFF_W +: IDX_W];
    assign fill_tag      = mem_addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign unused_pc_lsb = ^next_PC[1:0];

    generate
        if (BLOCK_WORDS > 1) begin : g_off
            assign off = next_PC[2 +: WRD_W];
        end else begin : g_no_off
            assign off = '0;
        end
    endgenerate

    // Tag compare across all ways of the addressed set; at most one way can match
    always_comb begin
        hit      = 1'b0;
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_mem[idx][w] == tag) begin
                hit      = 1'b1;
                hit_word = data_mem[idx][w][off];
            end
        end
    end

    // Victim for the outstanding refill: lowest invalid way, else the set's round-robin way
    always_comb begin
        victim = rr_q[fill_idx];
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid_q[fill_idx][w]) victim = WAY_W'(w);
    end

    // Miss FSM, counters and valid/rr updates; flush wipes valids and beats a same-cycle fill
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        rr_d       = rr_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        fill_we    = 1'b0;
        if (rdy_in) begin
            case (state_q)
                IDLE: begin
                    if (inst_en && hit) begin
                        hit_cnt_d = hit_cnt_q + 32'd1;
                    end else if (inst_en && !flush) begin
                        miss_cnt_d = miss_cnt_q + 32'd1;
                        mem_addr_d = {next_PC[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
                        mem_req_d  = 1'b1;
                        state_d    = MISS;
                    end
                end
                MISS: begin
                    if (flush) begin
                        mem_req_d = !resp_valid;
                        state_d   = resp_valid ? IDLE : DRAIN;
                    end else if (resp_valid) begin
                        fill_we                   = 1'b1;
                        valid_d[fill_idx][victim] = 1'b1;
                        rr_d[fill_idx]            = (WAYS == 1) ? '0 : rr_q[fill_idx] + WAY_W'(1);
                        mem_req_d                 = 1'b0;
                        state_d                   = IDLE;
                    end
                end
                DRAIN: begin
                    if (resp_valid) begin
                        mem_req_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (flush) valid_d = '0;
        end
    end

    // Control state with asynchronous reset; a reset mid-miss simply abandons the request
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            rr_q       <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            rr_q       <= rr_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone decide residency
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[fill_idx][victim]  <= fill_tag;
            data_mem[fill_idx][victim] <= resp_blk;
        end
    end

    assign cache_rdy     = !rst_in && inst_en && hit;
    assign next_inst_out = (!rst_in && hit) ? hit_word : '0;
    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign hit_cnt       = hit_cnt_q;
    assign miss_cnt      = miss_cnt_q;
endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: vector table, directed corner cases and random traffic against a reference model
module tb_icache_assoc;
    logic         clk = 1'b0;
    logic         rst_in = 1'b1;
    logic         rdy_in = 1'b1;
    logic         inst_en = 1'b0;
    logic [31:0]  next_PC = '0;
    logic         flush = 1'b0;
    logic         resp_valid = 1'b0;
    logic [127:0] resp_blk = '0;
    logic         cache_rdy, mem_req;
    logic [31:0]  next_inst_out, mem_addr, hit_cnt, miss_cnt;

    int errors = 0;
    int checks = 0;

    icache_assoc dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .inst_en(inst_en), .next_PC(next_PC),
        .flush(flush), .cache_rdy(cache_rdy), .next_inst_out(next_inst_out), .mem_req(mem_req),
        .mem_addr(mem_addr), .resp_valid(resp_valid), .resp_blk(resp_blk),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: 16 sets x 2 ways, 4-word blocks, described from the cache rules directly
    bit           m_v   [16][2];
    logic [23:0]  m_tag [16][2];
    logic [127:0] m_blk [16][2];
    int           m_rr  [16];
    int           m_mode;
    bit           m_req;
    logic [31:0]  m_addr, m_hits, m_miss;

    function automatic void m_reset();
        for (int s = 0; s < 16; s++) begin
            m_rr[s] = 0;
            for (int k = 0; k < 2; k++) m_v[s][k] = 0;
        end
        m_mode = 0; m_req = 0; m_addr = 0; m_hits = 0; m_miss = 0;
    endfunction

    function automatic void m_look(input logic [31:0] pc, output bit h, output logic [31:0] w);
        h = 0; w = 0;
        for (int k = 0; k < 2; k++)
            if (m_v[pc[7:4]][k] && m_tag[pc[7:4]][k] == pc[31:8]) begin
                h = 1;
                w = m_blk[pc[7:4]][k][32*pc[3:2] +: 32];
            end
    endfunction

    function automatic void m_edge();
        bit h;
        logic [31:0] w;
        int s, v;
        if (!rdy_in) return;
        m_look(next_PC, h, w);
        if (m_mode == 0) begin
            if (inst_en && h) m_hits++;
            else if (inst_en && !flush) begin
                m_miss++; m_addr = next_PC & ~32'hF; m_req = 1; m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (flush) begin
                if (resp_valid) begin m_req = 0; m_mode = 0; end
                else m_mode = 2;
            end else if (resp_valid) begin
                s = int'(m_addr[7:4]); v = -1;
                for (int k = 0; k < 2; k++) if (!m_v[s][k] && v < 0) v = k;
                if (v < 0) v = m_rr[s];
                m_v[s][v] = 1; m_tag[s][v] = m_addr[31:8]; m_blk[s][v] = resp_blk;
                m_rr[s] = (m_rr[s] + 1) % 2;
                m_req = 0; m_mode = 0;
            end
        end else if (resp_valid) begin
            m_req = 0; m_mode = 0;
        end
        if (flush) for (int a = 0; a < 16; a++) for (int k = 0; k < 2; k++) m_v[a][k] = 0;
    endfunction

    // Entered at a negedge with inputs applied; checks lookup, clocks once, checks registered state
    task automatic run_cycle();
        bit h;
        logic [31:0] w;
        #1;
        m_look(next_PC, h, w);
        chk("cache_rdy", cache_rdy, inst_en && h);
        chk("next_inst_out", next_inst_out, h ? w : 32'h0);
        m_edge();
        @(posedge clk); #1;
        chk("mem_req", mem_req, m_req);
        chk("mem_addr", mem_addr, m_addr);
        chk("hit_cnt", hit_cnt, m_hits);
        chk("miss_cnt", miss_cnt, m_miss);
        @(negedge clk);
    endtask

    task automatic cyc(input bit en, input logic [31:0] pc, input bit fl, input bit rv,
                       input bit rdy, input logic [127:0] blk);
        inst_en = en; next_PC = pc; flush = fl; resp_valid = rv; rdy_in = rdy; resp_blk = blk;
        run_cycle();
    endtask

    task automatic do_reset();
        rst_in = 1; inst_en = 1; next_PC = 0; flush = 0; resp_valid = 0; rdy_in = 1;
        m_reset();
        @(negedge clk); #1;
        chk("rst_cache_rdy", cache_rdy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        rst_in = 0; inst_en = 0;
        @(negedge clk);
    endtask

    typedef struct {
        bit          en;
        logic [31:0] pc;
        bit          fl;
        bit          rv;
        logic [31:0] base;
        bit          e_rdy;
        logic [31:0] e_inst;
        bit          e_req;
        logic [31:0] e_addr;
        logic [31:0] e_hit;
        logic [31:0] e_miss;
    } vec_t;

    vec_t vt[17];

    initial begin
        logic [31:0] h0;
        vt[0]  = '{1, 32'h008, 0, 0, 32'h0,        0, 32'h0,        1, 32'h000, 0, 1};
        vt[1]  = '{1, 32'h008, 0, 1, 32'hDEADBEED, 0, 32'h0,        0, 32'h000, 0, 1};
        vt[2]  = '{1, 32'h008, 0, 0, 32'h0,        1, 32'hDEADBEEF, 0, 32'h000, 1, 1};
        vt[3]  = '{1, 32'h100, 0, 0, 32'h0,        0, 32'h0,        1, 32'h100, 1, 2};
        vt[4]  = '{1, 32'h100, 0, 1, 32'h1000,     0, 32'h0,        0, 32'h100, 1, 2};
        vt[5]  = '{1, 32'h104, 0, 0, 32'h0,        1, 32'h1001,     0, 32'h100, 2, 2};
        vt[6]  = '{1, 32'h000, 0, 0, 32'h0,        1, 32'hDEADBEED, 0, 32'h100, 3, 2};
        vt[7]  = '{1, 32'h200, 0, 0, 32'h0,        0, 32'h0,        1, 32'h200, 3, 3};
        vt[8]  = '{1, 32'h200, 0, 1, 32'h2000,     0, 32'h0,        0, 32'h200, 3, 3};
        vt[9]  = '{1, 32'h100, 0, 0, 32'h0,        1, 32'h1000,     0, 32'h200, 4, 3};
        vt[10] = '{1, 32'h20C, 0, 0, 32'h0,        1, 32'h2003,     0, 32'h200, 5, 3};
        vt[11] = '{1, 32'h000, 0, 0, 32'h0,        0, 32'h0,        1, 32'h000, 5, 4};
        vt[12] = '{0, 32'h000, 1, 0, 32'h0,        0, 32'h0,        1, 32'h000, 5, 4};
        vt[13] = '{1, 32'h100, 0, 1, 32'h5000,     0, 32'h0,        0, 32'h000, 5, 4};
        vt[14] = '{1, 32'h000, 0, 0, 32'h0,        0, 32'h0,        1, 32'h000, 5, 5};
        vt[15] = '{0, 32'h000, 0, 1, 32'h6000,     0, 32'h0,        0, 32'h000, 5, 5};
        vt[16] = '{1, 32'h008, 0, 0, 32'h0,        1, 32'h6002,     0, 32'h000, 6, 5};

        do_reset();
        for (int i = 0; i < 17; i++) begin
            inst_en = vt[i].en; next_PC = vt[i].pc; flush = vt[i].fl; resp_valid = vt[i].rv;
            resp_blk = {vt[i].base + 32'd3, vt[i].base + 32'd2, vt[i].base + 32'd1, vt[i].base};
            #1;
            chk($sformatf("vec%0d cache_rdy", i), cache_rdy, vt[i].e_rdy);
            chk($sformatf("vec%0d next_inst_out", i), next_inst_out, vt[i].e_inst);
            @(posedge clk); #1;
            chk($sformatf("vec%0d mem_req", i), mem_req, vt[i].e_req);
            chk($sformatf("vec%0d mem_addr", i), mem_addr, vt[i].e_addr);
            chk($sformatf("vec%0d hit_cnt", i), hit_cnt, vt[i].e_hit);
            chk($sformatf("vec%0d miss_cnt", i), miss_cnt, vt[i].e_miss);
            @(negedge clk);
        end

        // rdy_in low for five cycles while a miss is outstanding
        do_reset();
        cyc(1, 32'h40, 0, 0, 1, '0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, (i % 2) ? 32'h80 : 32'hC4, 0, 0, 0, '0);
            chk("hold_mem_req", mem_req, 1);
            chk("hold_mem_addr", mem_addr, 32'h40);
            chk("hold_miss_cnt", miss_cnt, 1);
        end
        cyc(1, 32'h40, 0, 1, 1, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        cyc(1, 32'h48, 0, 0, 1, '0);
        chk("resume_fill_word", next_inst_out, 32'hA2);

        // hit-under-miss: 0x000 resident, miss outstanding on 0x300
        cyc(1, 32'h000, 0, 0, 1, '0);
        cyc(0, 32'h000, 0, 1, 1, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
        cyc(1, 32'h300, 0, 0, 1, '0);
        h0 = hit_cnt;
        cyc(1, 32'h004, 0, 0, 1, '0);
        chk("hum_cache_rdy", cache_rdy, 1);
        chk("hum_inst", next_inst_out, 32'hB1);
        chk("hum_hit_cnt", hit_cnt, h0);

        // flush and response in the same MISS cycle: fill dropped, miss relaunches
        cyc(1, 32'h300, 1, 1, 1, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
        chk("fr_mem_req", mem_req, 0);
        cyc(1, 32'h300, 0, 0, 1, '0);
        chk("fr_relaunch_req", mem_req, 1);
        chk("fr_relaunch_addr", mem_addr, 32'h300);

        // asynchronous reset between edges while a miss is outstanding
        cyc(0, 32'h300, 0, 1, 1, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
        cyc(1, 32'h000, 0, 0, 1, '0);
        inst_en = 1; next_PC = 32'h308; resp_valid = 0;
        #1;
        chk("pre_rst_hit", cache_rdy, 1);
        chk("pre_rst_inst", next_inst_out, 32'hD2);
        #1 rst_in = 1;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_cache_rdy", cache_rdy, 0);
        chk("arst_hit_cnt", hit_cnt, 0);
        chk("arst_miss_cnt", miss_cnt, 0);
        #1 rst_in = 0;
        m_reset();
        @(negedge clk);
        cyc(1, 32'h308, 0, 0, 1, '0);

        // random traffic over a small address pool so sets conflict and evict
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit rdy, rv;
            logic [31:0] pc;
            rdy = ($urandom % 10) != 0;
            rv  = rdy && ((m_mode != 0 && ($urandom % 3) == 0) || ($urandom % 25) == 0);
            pc  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 1) << 4) | ($urandom & 32'hF);
            cyc(($urandom % 5) != 0, pc, ($urandom % 40) == 0, rv, rdy,
                {$urandom, $urandom, $urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/icache_assoc.md
# icache_assoc

Parametrised set-associative instruction cache sitting between the instruction fetch unit and the memory controller. It generalises the direct-mapped icache in three ways: configurable way count, set count and block size; an internal miss state machine with a request/response handshake toward memory; and whole-cache flush plus hit/miss counters. Hits return the instruction combinationally in the same cycle. A miss issues one block-aligned refill request and installs the returned block into a victim way.

## Interface
- ADDR_WIDTH, 32, fetch address width
- INST_WIDTH, 32, instruction width
- WAYS, 2, associativity; power of two, 1..8
- SETS, 16, number of sets; power of two, at least 2
- BLOCK_WORDS, 4, instructions per block; power of two, at least 1
- Derived widths:
  - OFF_W = log2(BLOCK_WORDS) + 2
  - IDX_W = log2(SETS)
  - TAG_W = ADDR_WIDTH − IDX_W − OFF_W
  - BLK_W = BLOCK_WORDS × INST_WIDTH

Ports:
- clk  in  1  clock; the single clock, all state on rising edge
- rst_in  in  1  reset, asynchronous, active-high
- rdy_in  in  1  global enable; when low, no state changes
- inst_en  in  1  fetch request valid
- next_PC  in  ADDR_WIDTH  fetch address; bits [1:0] ignored
- flush  in  1  invalidate every line
- cache_rdy  out  1  inst_en && hit
- next_inst_out  out  INST_WIDTH  hit word; 0 when no hit
- mem_req  out  1  refill request, registered
- mem_addr  out  ADDR_WIDTH  refill block address, low OFF_W bits zero, registered
- resp_valid  in  1  refill data valid, one-cycle pulse
- resp_blk  in  BLK_W  refill block; word i at bits [i×INST_WIDTH +: INST_WIDTH]
- hit_cnt  out  32  hit counter, wraps at 2^32
- miss_cnt  out  32  miss counter, wraps at 2^32

## Operation
- Address split: offset = next_PC[OFF_W−1:2], index = next_PC[OFF_W+IDX_W−1:OFF_W], tag = upper TAG_W bits.
- Storage per set and way: valid bit, tag, block. Per set: round-robin pointer of log2(WAYS) bits.
- Lookup is combinational in every state (hit-under-miss allowed). At most one way matches.
- FSM states:
  - IDLE: if inst_en && !hit && !flush, latch the block address of next_PC into mem_addr, set mem_req=1, go to MISS.
  - MISS: mem_req held at 1 until resp_valid. On resp_valid, write resp_blk to the victim way of the latched index, set valid, set tag, increment that set's rr pointer mod WAYS, clear mem_req, go to IDLE.
  - DRAIN: entered from MISS on flush. mem_req stays 1. On resp_valid, data is discarded, mem_req cleared, go to IDLE.
- Victim selection: the lowest-numbered invalid way in the set; if all ways are valid, rr[set].
- flush: clears all valid bits in one edge; rr pointers are unchanged. In IDLE, flush suppresses the miss launch that cycle.
- Counters increment only in IDLE with inst_en: hit_cnt on a hit, miss_cnt on a miss launch.
- Changes to next_PC during MISS do not alter the outstanding request. Misses seen in MISS or DRAIN are neither counted nor launched.
- resp_valid in IDLE is ignored.
- rdy_in low: FSM, arrays, counters and mem_req/mem_addr all hold. Combinational outputs still follow the inputs. A resp_valid arriving while rdy_in is low is lost; the memory controller must not send one then.

## Timing
- Hit: cache_rdy and next_inst_out are valid in the same cycle as next_PC.
- Miss launch at edge E0; mem_req=1 from E0. Response pulse in cycle N; fill written at that edge. Hit on the same PC from the next cycle: minimum miss-to-hit of 2 cycles when the response arrives in the first MISS cycle.
- Reset (async, immediate): all valid=0, rr=0, state IDLE, mem_req=0, mem_addr=0, counters 0. cache_rdy=0 and next_inst_out=0 while in reset. Reset mid-MISS abandons the request; the memory controller is reset by the same rst_in.
- flush and resp_valid in the same MISS cycle: the fill is discarded and the state goes to IDLE. Flush has priority over the fill.

## Test plan
- Cold miss: reset, inst_en=1, PC=0x0000_0008 -> cache_rdy=0; mem_req=1 and mem_addr=0x0 the next cycle. Respond with a block whose word2=0xDEADBEEF -> the cycle after: cache_rdy=1, next_inst_out=0xDEADBEEF, hit_cnt=1, miss_cnt=1.
- Conflict and replacement (WAYS=2, SETS=16, BLOCK_WORDS=4): fill 0x000, then 0x100 -> both hit. Fill 0x200 -> way0 evicted: 0x000 misses, 0x100 still hits.
- Flush during miss: launch miss on 0x40, assert flush, then resp_valid -> no line written, 0x40 misses again, mem_req=1 once more.
- rdy_in low for 5 cycles in MISS with a toggling next_PC -> mem_req and mem_addr hold, counters hold. Resume and respond -> correct fill.
- Async reset asserted mid-MISS between clock edges -> mem_req=0 immediately, all lookups miss, counters=0.
- Hit-under-miss: 0x000 resident, miss outstanding on 0x300, PC switched to 0x004 -> cache_rdy=1 and hit_cnt unchanged.
